demux1x8_4b_seq: RTL

Registered 1-to-8 demultiplexer of 4-bit nibbles. It is the inverse of the 8-to-1 nibble multiplexer path: it takes a stream of nibbles and distributes them into eight held output lanes o0..o7. Lanes are selected either directly by s2..s0 or automatically by an internal round-robin pointer. A frame-complete handshake tells the consumer when all eight lanes hold fresh data.

---
 rtl/demux1x8_4b_seq_if.sv | 32 +++
 rtl/demux1x8_4b_seq.sv | 88 ++++++++
 2 files changed

// File: rtl/demux1x8_4b_seq_if.sv
// Bus between the nibble producer/consumer and the registered 1-to-8 demux.
// The slave modport is the demux side; master is the producer/consumer side.
interface demux1x8_4b_seq_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] d;
  logic             s0;
  logic             s1;
  logic             s2;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             ack;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [WIDTH-1:0] o4;
  logic [WIDTH-1:0] o5;
  logic [WIDTH-1:0] o6;
  logic [WIDTH-1:0] o7;
  logic [7:0]       lane_valid;
  logic             frame_done;

  modport master (
    output d, s0, s1, s2, mode, in_valid, ack,
    input  in_ready, o0, o1, o2, o3, o4, o5, o6, o7, lane_valid, frame_done
  );

  modport slave (
    input  d, s0, s1, s2, mode, in_valid, ack,
    output in_ready, o0, o1, o2, o3, o4, o5, o6, o7, lane_valid, frame_done
  );
endinterface

// File: rtl/demux1x8_4b_seq.sv
// Registered 1-to-8 nibble demultiplexer with direct or round-robin lane
// selection and a frame-complete handshake released by ack.
module demux1x8_4b_seq #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  demux1x8_4b_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] lane_data [8];
  logic [7:0]       lane_valid_q;
  logic [7:0]       lane_valid_next;
  logic [2:0]       ptr;
  logic [2:0]       lane;
  logic             accept;
  logic             release_frame;
  logic             frame_full;
  logic             frame_done_q;
  logic             in_ready_c;

  always_comb begin
    lane            = bus.mode ? ptr : {bus.s2, bus.s1, bus.s0};
    accept          = bus.in_valid && in_ready_c;
    release_frame   = bus.ack && (state != IDLE);
    lane_valid_next = accept ? (lane_valid_q | (8'b1 << lane)) : lane_valid_q;
    frame_full      = accept && (lane_valid_next == 8'hFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = FILL;
      FILL: begin
        if (bus.ack)         state_next = IDLE;
        else if (frame_full) state_next = FULL;
      end
      FULL:    if (bus.ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is held low throughout reset, not just by the reset state value.
  always_comb begin
    in_ready_c = rst_n && (state != FULL) && !bus.ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) lane_data[i] <= '0;
      lane_valid_q <= '0;
      ptr          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state == FILL) && frame_full;
      if (release_frame) begin
        lane_valid_q <= '0;
        ptr          <= '0;
      end else if (accept) begin
        lane_data[lane] <= bus.d;
        lane_valid_q    <= lane_valid_next;
        if (bus.mode) ptr <= ptr + 3'd1;
      end
    end
  end

  assign bus.o0         = lane_data[0];
  assign bus.o1         = lane_data[1];
  assign bus.o2         = lane_data[2];
  assign bus.o3         = lane_data[3];
  assign bus.o4         = lane_data[4];
  assign bus.o5         = lane_data[5];
  assign bus.o6         = lane_data[6];
  assign bus.o7         = lane_data[7];
  assign bus.lane_valid = lane_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.in_ready   = in_ready_c;

endmodule
